// File: rtl/dragon_body.sv
`default_nettype none
// ============================================================================
// dragon_body : trailing body-segment chain following the dragon head
// Rev 1.0
// ============================================================================
module dragon_body #(
  parameter int MAX_SEGS = 8,
  parameter int INIT_LEN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            head_pos,
  input  logic [1:0]            head_dir,
  input  logic                  head_move,
  input  logic                  grow,
  input  logic                  shrink,
  output logic [8*MAX_SEGS-1:0] seg_pos,
  output logic [2*MAX_SEGS-1:0] seg_dir,
  output logic [MAX_SEGS-1:0]   seg_valid,
  output logic [3:0]            length,
  output logic [7:0]            tail_pos,
  output logic                  self_hit
);

  localparam logic [3:0] c_max_len  = 4'(MAX_SEGS);
  localparam logic [3:0] c_init_len = 4'(INIT_LEN);

  logic [7:0] pos_q [MAX_SEGS];
  logic [1:0] dir_q [MAX_SEGS];
  logic [7:0] prev_pos_q;
  logic [1:0] prev_dir_q;
  logic [3:0] length_q, length_d;
  logic       self_hit_q, self_hit_d;
  logic [7:0] w_cand [MAX_SEGS];
  logic [7:0] w_tail;

  always_comb begin
    length_d = length_q;
    if (grow && !shrink && (length_q < c_max_len)) begin
      length_d = length_q + 4'd1;
    end else if (shrink && !grow && (length_q > 4'd1)) begin
      length_d = length_q - 4'd1;
    end
  end

  // Slot positions as they will be once this step's shift has landed.
  assign w_cand[0] = prev_pos_q;
  generate
    for (genvar gi = 1; gi < MAX_SEGS; gi++) begin : g_cand
      assign w_cand[gi] = pos_q[gi-1];
    end
  endgenerate

  always_comb begin
    self_hit_d = 1'b0;
    if (head_move) begin
      for (int i = 0; i < MAX_SEGS; i++) begin
        if ((4'(i) < length_d) && (head_pos == w_cand[i])) begin
          self_hit_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_SEGS; i++) begin
        pos_q[i] <= 8'h00;
        dir_q[i] <= 2'b00;
      end
      prev_pos_q <= 8'h00;
      prev_dir_q <= 2'b00;
      length_q   <= c_init_len;
      self_hit_q <= 1'b0;
    end else begin
      length_q   <= length_d;
      self_hit_q <= self_hit_d;
      // Every slot shifts, so hidden slots keep genuine trail history.
      if (head_move) begin
        pos_q[0] <= prev_pos_q;
        dir_q[0] <= prev_dir_q;
        for (int i = 1; i < MAX_SEGS; i++) begin
          pos_q[i] <= pos_q[i-1];
          dir_q[i] <= dir_q[i-1];
        end
        prev_pos_q <= head_pos;
        prev_dir_q <= head_dir;
      end
    end
  end

  always_comb begin
    w_tail = 8'h00;
    for (int i = 0; i < MAX_SEGS; i++) begin
      if (4'(i) == (length_q - 4'd1)) begin
        w_tail = pos_q[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_SEGS; gi++) begin : g_pack
      assign seg_pos[8*gi +: 8] = pos_q[gi];
      assign seg_dir[2*gi +: 2] = dir_q[gi];
      assign seg_valid[gi]      = (4'(gi) < length_q);
    end
  endgenerate

  assign length   = length_q;
  assign tail_pos = w_tail;
  assign self_hit = self_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_dragon_body.sv
`default_nettype none
// ============================================================================
// tb_dragon_body : scoreboard bench for dragon_body
// Rev 1.0
// ============================================================================
module tb_dragon_body;

  localparam int MS = 8;
  localparam int IL = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      head_pos = 8'h00;
  logic [1:0]      head_dir = 2'b00;
  logic            head_move = 1'b0;
  logic            grow = 1'b0;
  logic            shrink = 1'b0;
  logic [8*MS-1:0] seg_pos;
  logic [2*MS-1:0] seg_dir;
  logic [MS-1:0]   seg_valid;
  logic [3:0]      length;
  logic [7:0]      tail_pos;
  logic            self_hit;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dragon_body #(.MAX_SEGS(MS), .INIT_LEN(IL)) dut (
    .clk(clk), .reset(reset), .head_pos(head_pos), .head_dir(head_dir),
    .head_move(head_move), .grow(grow), .shrink(shrink),
    .seg_pos(seg_pos), .seg_dir(seg_dir), .seg_valid(seg_valid),
    .length(length), .tail_pos(tail_pos), .self_hit(self_hit)
  );

  typedef struct {
    logic [8*MS-1:0] pos;
    logic [2*MS-1:0] dir;
    logic [MS-1:0]   valid;
    logic [3:0]      len;
    logic [7:0]      tail;
    logic            hit;
  } exp_t;

  exp_t exp_q[$];

  // Reference state of the chain
  logic [7:0] m_pos [MS];
  logic [1:0] m_dir [MS];
  logic [7:0] m_prev_pos = 8'h00;
  logic [1:0] m_prev_dir = 2'b00;
  int         m_len = IL;

  initial begin
    for (int i = 0; i < MS; i++) begin
      m_pos[i] = 8'h00;
      m_dir[i] = 2'b00;
    end
  end

  // Drive one cycle, advance the reference, queue the expected outputs.
  task automatic drive(input logic rst_n, input logic mv, input logic [7:0] p,
                       input logic [1:0] d, input logic g, input logic s);
    exp_t e;
    int   nl;
    logic h;
    logic [7:0] cand;
    reset = rst_n; head_move = mv; head_pos = p; head_dir = d; grow = g; shrink = s;
    h = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < MS; i++) begin
        m_pos[i] = 8'h00;
        m_dir[i] = 2'b00;
      end
      m_prev_pos = 8'h00;
      m_prev_dir = 2'b00;
      m_len = IL;
    end else begin
      nl = m_len;
      if (g && !s && m_len < MS) nl = m_len + 1;
      else if (s && !g && m_len > 1) nl = m_len - 1;
      if (mv) begin
        for (int i = 0; i < nl; i++) begin
          cand = (i == 0) ? m_prev_pos : m_pos[i-1];
          if (cand == p) h = 1'b1;
        end
        for (int i = MS - 1; i > 0; i--) begin
          m_pos[i] = m_pos[i-1];
          m_dir[i] = m_dir[i-1];
        end
        m_pos[0] = m_prev_pos;
        m_dir[0] = m_prev_dir;
        m_prev_pos = p;
        m_prev_dir = d;
      end
      m_len = nl;
    end
    for (int i = 0; i < MS; i++) begin
      e.pos[8*i +: 8] = m_pos[i];
      e.dir[2*i +: 2] = m_dir[i];
      e.valid[i]      = (i < m_len);
    end
    e.len  = 4'(m_len);
    e.tail = m_pos[m_len-1];
    e.hit  = h;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    reset = 1'b1; head_move = 1'b0; grow = 1'b0; shrink = 1'b0;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic step(input logic [7:0] p, input logic [1:0] d);
    drive(1'b1, 1'b1, p, d, 1'b0, 1'b0);
  endtask

  // Scoreboard: outputs sampled mid-cycle, after the edge that produced them
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (seg_pos !== e.pos) begin
        failures++; $display("FAIL sb_seg_pos got=%h exp=%h", seg_pos, e.pos);
      end
      checks++;
      if (seg_dir !== e.dir) begin
        failures++; $display("FAIL sb_seg_dir got=%h exp=%h", seg_dir, e.dir);
      end
      checks++;
      if (seg_valid !== e.valid) begin
        failures++; $display("FAIL sb_seg_valid got=%h exp=%h", seg_valid, e.valid);
      end
      checks++;
      if (length !== e.len) begin
        failures++; $display("FAIL sb_length got=%0d exp=%0d", length, e.len);
      end
      checks++;
      if (tail_pos !== e.tail) begin
        failures++; $display("FAIL sb_tail_pos got=%h exp=%h", tail_pos, e.tail);
      end
      checks++;
      if (self_hit !== e.hit) begin
        failures++; $display("FAIL sb_self_hit got=%b exp=%b", self_hit, e.hit);
      end
    end
  end

  task automatic test_reset();
    drive(1'b0, 1'b1, 8'h55, 2'b11, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h66, 2'b10, 1'b0, 1'b0);
    checks++;
    if (length !== 4'd2) begin failures++; $display("FAIL reset_length got=%0d exp=2", length); end
    checks++;
    if (seg_valid !== 8'h03) begin failures++; $display("FAIL reset_valid got=%h exp=03", seg_valid); end
    checks++;
    if (seg_pos !== '0) begin failures++; $display("FAIL reset_seg_pos got=%h exp=0", seg_pos); end
    checks++;
    if (self_hit !== 1'b0) begin failures++; $display("FAIL reset_self_hit got=%b exp=0", self_hit); end
  endtask

  task automatic test_trail();
    step(8'h10, 2'b01);
    step(8'h20, 2'b01);
    step(8'h21, 2'b10);
    checks++;
    if (seg_pos[7:0] !== 8'h20 || seg_dir[1:0] !== 2'b01) begin
      failures++; $display("FAIL trail_slot0 got=%h/%b exp=20/01", seg_pos[7:0], seg_dir[1:0]);
    end
    checks++;
    if (seg_pos[15:8] !== 8'h10 || seg_dir[3:2] !== 2'b01) begin
      failures++; $display("FAIL trail_slot1 got=%h/%b exp=10/01", seg_pos[15:8], seg_dir[3:2]);
    end
    checks++;
    if (seg_pos[23:16] !== 8'h00) begin
      failures++; $display("FAIL trail_slot2 got=%h exp=00", seg_pos[23:16]);
    end
    checks++;
    if (tail_pos !== 8'h10) begin failures++; $display("FAIL trail_tail got=%h exp=10", tail_pos); end
  endtask

  task automatic test_grow_exposes();
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    checks++;
    if (seg_valid !== 8'h07) begin failures++; $display("FAIL expose_valid got=%h exp=07", seg_valid); end
    checks++;
    if (tail_pos !== 8'h00) begin failures++; $display("FAIL expose_tail got=%h exp=00", tail_pos); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    checks++;
    if (length !== 4'd8) begin failures++; $display("FAIL grow_sat got=%0d exp=8", length); end
    checks++;
    if (tail_pos !== seg_pos[63:56]) begin
      failures++; $display("FAIL grow_sat_tail got=%h exp=%h", tail_pos, seg_pos[63:56]);
    end
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    checks++;
    if (length !== 4'd1) begin failures++; $display("FAIL shrink_sat got=%0d exp=1", length); end
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1);
    checks++;
    if (length !== 4'd3) begin failures++; $display("FAIL grow_shrink_both got=%0d exp=3", length); end
  endtask

  task automatic hit_path(input int grows);
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < grows; i++) drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    step(8'h10, 2'b01);
    step(8'h11, 2'b10);
    step(8'h01, 2'b11);
    step(8'h00, 2'b00);
  endtask

  task automatic test_self_hit();
    hit_path(2);
    checks++;
    if (self_hit !== 1'b1) begin failures++; $display("FAIL hit_len4 got=%b exp=1", self_hit); end
    idle();
    checks++;
    if (self_hit !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%b exp=0", self_hit); end
    hit_path(1);
    checks++;
    if (self_hit !== 1'b0) begin failures++; $display("FAIL hit_len3 got=%b exp=0", self_hit); end
    // Non-move with matching position must not flag a hit.
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    // A step onto the current head tile is a duplicate and hits slot 0.
    step(8'h00, 2'b01);
    checks++;
    if (self_hit !== 1'b1) begin failures++; $display("FAIL hit_duplicate got=%b exp=1", self_hit); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 7)),
            2'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
    end
  endtask

  task automatic test_mid_reset();
    step(8'h34, 2'b01);
    step(8'h35, 2'b10);
    drive(1'b1, 1'b1, 8'h36, 2'b10, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 8'h37, 2'b11, 1'b1, 1'b0);
    checks++;
    if (length !== 4'd2 || seg_valid !== 8'h03) begin
      failures++; $display("FAIL midreset_len got=%0d/%h exp=2/03", length, seg_valid);
    end
    checks++;
    if (seg_pos !== '0 || seg_dir !== '0 || tail_pos !== 8'h00) begin
      failures++; $display("FAIL midreset_pos got=%h/%h/%h exp=0", seg_pos, seg_dir, tail_pos);
    end
    // prev_pos must be cleared too: the first step after reset fills slot0 with 00.
    step(8'h44, 2'b01);
    checks++;
    if (seg_pos[7:0] !== 8'h00) begin
      failures++; $display("FAIL midreset_prev got=%h exp=00", seg_pos[7:0]);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_trail();
    test_grow_exposes();
    test_saturation();
    test_self_hit();
    test_back_to_back();
    test_mid_reset();
    idle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dragon_body.md
# dragon_body

Dragon body segment chain. Sits directly downstream of the dragon head movement stage: consumes the head's tile position and facing on every head step, and maintains a trailing chain of up to `MAX_SEGS` body segments. Each segment occupies the tile its predecessor held one step earlier. It drives the renderer and collision logic with per-segment position, direction and valid mask. It also flags when the head steps onto its own body.

## Interface
- `MAX_SEGS`, default 8: physical segment slots, range 2–15.
- `INIT_LEN`, default 2: active body length after reset, range 1–`MAX_SEGS`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `head_pos`  in  8  head tile position, {x[7:4], y[3:0]}; new value is valid in the cycle `head_move` is high.
- `head_dir`  in  2  head facing: 00 up, 01 right, 10 down, 11 left; sampled with `head_move`.
- `head_move`  in  1  single-cycle strobe: the head has advanced one tile.
- `grow`  in  1  single-cycle strobe: lengthen body by one.
- `shrink`  in  1  single-cycle strobe: shorten body by one.
- `seg_pos`  out  8*MAX_SEGS  segment positions; slot i is at bits [8i+7:8i]; slot 0 is adjacent to the head.
- `seg_dir`  out  2*MAX_SEGS  segment facings; slot i is at bits [2i+1:2i].
- `seg_valid`  out  MAX_SEGS  bit i = 1 iff i < `length`.
- `length`  out  4  current active segment count.
- `tail_pos`  out  8  equals `seg_pos` slot (`length`-1).
- `self_hit`  out  1  one-cycle pulse: head landed on an active segment.

## Operation
- Internal registers:
  - `prev_pos` (8b) and `prev_dir` (2b): the head's last accepted position and facing.
  - Segment array `seg[0..MAX_SEGS-1]`, each holding {pos, dir}.
- Step (`head_move`=1):
  - `seg[0]` <= {`prev_pos`, `prev_dir`}.
  - `seg[i]` <= `seg[i-1]` for i = 1..MAX_SEGS-1.
  - `prev_pos` <= `head_pos`, `prev_dir` <= `head_dir`.
- All `MAX_SEGS` slots shift on every step, whether active or not. Hidden slots therefore always hold true trail history, and a newly exposed segment appears at the correct trailing tile.
- Length control is evaluated every cycle, independently of `head_move`:
  - `grow` only: `length` + 1, saturating at `MAX_SEGS`.
  - `shrink` only: `length` - 1, saturating at 1.
  - `grow` and `shrink` together: no change.
- `seg_valid` and `tail_pos` are decoded from the registered `length`.
- Self-collision, evaluated only when `head_move`=1:
  - Compare `head_pos` against the post-shift slot positions, i.e. `prev_pos` for slot 0 and `seg[i-1].pos` for slot i.
  - Only slots i < the post-update `length` take part.
  - Any match sets `self_hit` for exactly the next cycle; otherwise `self_hit` = 0.
- `head_move` while `head_pos` == `prev_pos` (head did not actually move) is still treated as a step: duplicates are allowed, and `self_hit` fires because slot 0 matches.
- Reset (`reset`=0 at a clock edge) overrides every other input in that cycle:
  - All `seg` slots = {8'h00, 2'b00}; `prev_pos` = 8'h00; `prev_dir` = 2'b00.
  - `length` = `INIT_LEN`; `self_hit` = 0.
  - Resulting outputs: `seg_pos` all zero, `seg_dir` all zero, `seg_valid` = (1<<`INIT_LEN`)-1, `tail_pos` = 8'h00.
- Reset mid-chain discards all history; pending strobes in the reset cycle are ignored.

## Timing
- All outputs are registered.
- `seg_pos`, `seg_dir` and `self_hit` reflect a `head_move` seen in cycle N from cycle N+1.
- A `grow` or `shrink` seen in cycle N updates `length`, `seg_valid` and `tail_pos` from cycle N+1.
- `grow`/`shrink` coincident with `head_move`: the shift and the length change both take effect at the same edge, and the collision compare uses the new length.
- Back-to-back `head_move` pulses on consecutive cycles are legal; each cycle produces one shift.
- There is no handshake or backpressure; each strobe is consumed in the cycle it is asserted.
- Arithmetic: `length` is 4-bit unsigned with saturation at both bounds. Positions are copied, never computed, so no wrap-around is possible.

## Test plan
- Reset: assert `reset`=0 for 2 cycles with `head_move`=1 held high. Required: `length`=2, `seg_valid`=8'h03, all `seg_pos`=0, `self_hit`=0.
- Trail:
  - Stimulus: from reset, step head through 8'h10 (dir 01), 8'h20 (01), 8'h21 (10).
  - Required: slot0 = 8'h20 with dir 01, slot1 = 8'h10 with dir 01, slot2 (hidden) = 8'h00; `tail_pos` = 8'h10.
- Grow/shrink saturation:
  - 10 `grow` pulses: `length` reaches 8, and further pulses leave it at 8.
  - 10 `shrink` pulses: `length` stops at 1.
  - `grow` and `shrink` in the same cycle: `length` unchanged.
- Grow exposes history: after the trail scenario, one `grow` gives `seg_valid`=8'h07 and `tail_pos`=8'h00.
- Self-hit:
  - Stimulus: length 4; head path 8'h00→8'h10→8'h11→8'h01→8'h00.
  - Required: `self_hit`=1 for exactly one cycle after the final step, because 8'h00 matches slot 3. With length 3 the same path must give no pulse.
- Mid-run reset: reset during a stream of steps and a `grow`. The next cycle must show the reset values, and the `grow` must be ignored.
